// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared constants and types for the elastic pipeline register
package pipe_skid_stage_pkg;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } pipe_slot_t;
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one main+skid register pair with a valid/ready handshake
module pipe_skid_slot
  import pipe_skid_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP = WIDTH'(RV_NOP)
) (
  input  logic             clk,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             drain;
  assign in_ready = ~skid_valid & ~kill;
  assign accept   = in_valid & in_ready;
  assign drain    = ~out_valid | out_ready;
  assign count    = {1'b0, out_valid} + {1'b0, skid_valid};
  always_ff @(posedge clk)
    if (kill) begin
      out_valid  <= 1'b0;
      out_data   <= NOP;
      skid_valid <= 1'b0;
      skid_data  <= NOP;
    end else if (drain) begin
      out_valid  <= skid_valid | accept;
      out_data   <= skid_valid ? skid_data : accept ? in_data : NOP;
      skid_valid <= 1'b0;
      skid_data  <= NOP;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: chain of skid slots with flush, occupancy and saturating stall counter
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          STAGES    = 1,
  parameter logic [31:0] NOP_VALUE = RV_NOP,
  parameter int          CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy,
  output logic [CNT_W-1:0]                 stall_cycles
);
  localparam int OCC_W = $clog2(2*STAGES+1);
  localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_VALUE);
  logic             kill;
  logic [STAGES:0]  v;
  logic [STAGES:0]  r;
  logic [WIDTH-1:0] d [STAGES+1];
  logic [1:0]       cnt [STAGES];
  assign kill      = flush | ~reset;
  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign in_ready  = r[0];
  assign out_valid = v[STAGES];
  assign out_data  = d[STAGES];
  assign r[STAGES] = out_ready;
  for (genvar s = 0; s < STAGES; s++) begin : g_slot
    pipe_skid_slot #(.WIDTH(WIDTH), .NOP(NOP)) u_slot (
      .clk      (clk),
      .kill     (kill),
      .in_valid (v[s]),
      .in_ready (r[s]),
      .in_data  (d[s]),
      .out_valid(v[s+1]),
      .out_ready(r[s+1]),
      .out_data (d[s+1]),
      .count    (cnt[s])
    );
  end
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCC_W'(cnt[i]);
  end
  always_ff @(posedge clk)
    if (!reset) stall_cycles <= '0;
    else if (out_valid & ~out_ready & ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
endmodule
